// File: rtl/serial_bus_pkg.sv
// Shared types and line-level constants for the serial bus slave endpoint.
package serial_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MODE,
      ADDR,
      WDATA,
      WACK,
      RREAD,
      RDATA
   } slave_state_t;

   localparam logic MODE_WRITE = 1'b1;
   localparam logic MODE_READ  = 1'b0;
   localparam logic START_BIT  = 1'b1;
   localparam logic IDLE_LEVEL = 1'b0;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slave_mem.sv
// Local register-file memory: synchronous write, registered read, out-of-range guard.
module slave_mem #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 2048
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  in_range_c;
   logic [IDX_W-1:0]      idx_c;

   // One extra bit keeps the compare exact when MEM_DEPTH == 2**ADDR_WIDTH.
   assign in_range_c = ((ADDR_WIDTH+1)'(addr_i) < (ADDR_WIDTH+1)'(MEM_DEPTH));
   assign idx_c      = IDX_W'(addr_i);

   always_ff @(posedge clk_i) begin
      if (we_i && in_range_c) begin
         mem_q[idx_c] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= in_range_c ? mem_q[idx_c] : '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_slave_port.sv
// Slave endpoint: deserialises request frames, accesses local memory and
// serialises a write acknowledge or read response back onto tx.
module serial_slave_port
   import serial_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MEM_DEPTH  = 2048
) (
   input  logic clk,
   input  logic rstn,
   input  logic rx,
   output logic tx,
   output logic busy
);

   localparam int unsigned CNT_W  = $clog2(max_u(ADDR_WIDTH, DATA_WIDTH) + 1);
   localparam int unsigned DIDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   slave_state_t          state_q, state_d;
   logic                  mode_q, mode_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  tx_q, tx_d;
   logic                  busy_q;

   logic                  mem_we_c;
   logic                  mem_re_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic [DATA_WIDTH-1:0] rdata_c;

   slave_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .rst_ni  (rstn),
      .we_i    (mem_we_c),
      .re_i    (mem_re_c),
      .addr_i  (addr_q),
      .wdata_i (wdata_c),
      .rdata_o (rdata_c)
   );

   // Next-state, shift and response logic; tx defaults to the idle level.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      tx_d     = IDLE_LEVEL;
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;
      wdata_c  = {rx, data_q[DATA_WIDTH-1:1]};

      case (state_q)
         IDLE: begin
            if (rx == START_BIT) state_d = MODE;
         end
         MODE: begin
            mode_d  = rx;
            cnt_d   = '0;
            state_d = ADDR;
         end
         ADDR: begin
            addr_d = {rx, addr_q[ADDR_WIDTH-1:1]};
            if (cnt_q == CNT_W'(ADDR_WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = (mode_q == MODE_WRITE) ? WDATA : RREAD;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WDATA: begin
            data_d = wdata_c;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
               mem_we_c = 1'b1;
               tx_d     = START_BIT;
               cnt_d    = '0;
               state_d  = WACK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WACK: begin
            state_d = IDLE;
         end
         RREAD: begin
            mem_re_c = 1'b1;
            tx_d     = START_BIT;
            cnt_d    = '0;
            state_d  = RDATA;
         end
         RDATA: begin
            // Count runs to DATA_WIDTH so the closing tx=0 edge stays inside RDATA.
            if (cnt_q == CNT_W'(DATA_WIDTH)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               tx_d  = rdata_c[DIDX_W'(cnt_q)];
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         mode_q  <= MODE_READ;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         tx_q    <= IDLE_LEVEL;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Slave-side endpoint of the serial bus; one instance sits behind each slave port (sN_rx into the endpoint, sN_tx out of it).
- Deserialises request frames routed by the address decoder.
- Performs writes and reads against a local register-file memory.
- Serialises read data, or a write acknowledge, back toward the bus.

Parameters:
- ADDR_WIDTH, 12, number of address bits carried in a request frame.
- DATA_WIDTH, 8, data word width (write payload and read response).
- MEM_DEPTH, 2048, number of implemented words; must satisfy MEM_DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- rx  input  1  serial request line from the bus (the slave's s_rx).
- tx  output  1  registered serial response line to the bus (the slave's s_tx).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Line encoding: idle level is 0. All fields are sent LSB first, one bit per clk. "Edge k" means the rising edge that samples bit k.
- Request frame: start(1), mode (1=write, 0=read), addr[ADDR_WIDTH], then data[DATA_WIDTH] for writes only.
- States and transitions:
  - IDLE: rx=1 → MODE.
  - MODE: latch mode bit; clear bit counter → ADDR.
  - ADDR: shift rx into addr. After ADDR_WIDTH bits: write → WDATA, read → RREAD.
  - WDATA: shift rx into data. On the edge sampling the last bit, commit the write and set tx=1 → WACK.
  - WACK: clear tx to 0 → IDLE.
  - RREAD: synchronous memory read. On this edge, set tx=1 (response start bit) → RDATA.
  - RDATA: drive tx=rdata[cnt] for DATA_WIDTH cycles, then tx=0 → IDLE.
- Latency:
  - Write ack: tx is high for exactly one clock, starting at the edge that samples the last data bit.
  - Read: response start bit appears one edge after the last address bit; data bit 0 follows one edge later.
- Response frame: start(1) then DATA_WIDTH data bits. tx returns to 0 after the last bit.
- Bit counter: width $clog2(max(ADDR_WIDTH, DATA_WIDTH)+1); counts 0..N-1 per field; no wrap.
- Out of range (addr >= MEM_DEPTH):
  - write is discarded, ack still sent;
  - read returns all-zero data with normal framing and timing.
- rx is ignored in every state except IDLE, MODE, ADDR and WDATA. A 1 on rx during WACK/RREAD/RDATA does not start a new frame. The first new start bit can be sampled on the edge after return to IDLE.
- Back-to-back frames: a start bit sampled in the cycle immediately after returning to IDLE must be accepted.
- Reset (including mid-frame or mid-response): state=IDLE, tx=0, busy=0, counters and shift registers cleared. Memory contents are not reset and are undefined until written.
- busy: registered, follows state. 0 in IDLE, 1 in all other states.

Decomposition:
- Package serial_bus_pkg:
  - state enum slave_state_t {IDLE, MODE, ADDR, WDATA, WACK, RREAD, RDATA};
  - constants MODE_WRITE=1'b1, MODE_READ=1'b0, START_BIT=1'b1, IDLE_LEVEL=1'b0.
- One sub-module, slave_mem:
  - MEM_DEPTH x DATA_WIDTH array, synchronous write, registered read;
  - handles the out-of-range guard (write suppressed, read returns 0).

Test Plan:
- Write 0xA5 to addr 0x005 (22-bit frame) → tx=1 for exactly one cycle after edge 21, busy=0 after edge 22; internal mem[5]=0xA5.
- Read addr 0x005 after the above → tx start bit after edge 14, then bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) after edges 15..22, tx=0 after edge 23.
- Write 0x3C to addr 0x7FF, immediately followed by a start bit on the cycle after IDLE, reading 0x7FF → second frame accepted, response data 0x3C.
- Read addr 0x800 (>= MEM_DEPTH) → well-framed response with data 0x00. A prior write of 0xFF to 0x800 → ack pulse only, no aliasing into mem[0].
- Assert rstn=0 at address bit 6 of a read, release, then send a write of 0x11 to 0x001 → tx=0 and busy=0 during reset; next frame decoded correctly; readback 0x11.
- Hold rx=1 throughout an RDATA response → response bits are unaffected and no frame starts until IDLE is re-entered.
